// File: rtl/sw_stream_driver.sv
// Streams host-loaded reference/query symbol buffers to a Smith-Waterman aligner,
// then captures its result on a finish rising edge or flags a watchdog timeout.
module sw_stream_driver #(
  parameter int WIDTH_SCORE     = 8,
  parameter int WIDTH_POS_REF   = 7,
  parameter int WIDTH_POS_QUERY = 6,
  parameter int LEN_REF         = 64,
  parameter int LEN_QUERY       = 48
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic                       wr_sel,
  input  logic [5:0]                 wr_addr,
  input  logic [1:0]                 wr_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic                       valid,
  output logic [1:0]                 data_ref,
  output logic [1:0]                 data_query,
  input  logic                       finish,
  input  logic [WIDTH_SCORE-1:0]     max,
  input  logic [WIDTH_POS_REF-1:0]   pos_ref,
  input  logic [WIDTH_POS_QUERY-1:0] pos_query,
  output logic [WIDTH_SCORE-1:0]     res_max,
  output logic [WIDTH_POS_REF-1:0]   res_pos_ref,
  output logic [WIDTH_POS_QUERY-1:0] res_pos_query
);

  localparam int KW  = 7;
  localparam int AWR = $clog2(LEN_REF);
  localparam int AWQ = $clog2(LEN_QUERY);
  localparam logic [KW-1:0] K_REF  = KW'(LEN_REF);
  localparam logic [KW-1:0] K_QRY  = KW'(LEN_QUERY);
  localparam logic [KW-1:0] K_ZERO = {KW{1'b0}};
  localparam logic [KW-1:0] K_ONE  = {{(KW-1){1'b0}}, 1'b1};
  localparam logic [9:0]    WD_MAX = 10'd1023;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [1:0] ref_mem [LEN_REF];
  logic [1:0] qry_mem [LEN_QUERY];

  logic [KW-1:0]              k_q, k_d;
  logic [9:0]                 wd_q, wd_d;
  logic                       finish_dly_q;
  logic                       valid_q, valid_d;
  logic [1:0]                 data_ref_q, data_ref_d;
  logic [1:0]                 data_query_q, data_query_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       timeout_q, timeout_d;
  logic [WIDTH_SCORE-1:0]     res_max_q, res_max_d;
  logic [WIDTH_POS_REF-1:0]   res_pos_ref_q, res_pos_ref_d;
  logic [WIDTH_POS_QUERY-1:0] res_pos_query_q, res_pos_query_d;

  logic [KW-1:0] wr_addr_ext_s;
  logic [KW-1:0] idx_s;
  logic          wr_ref_s;
  logic          wr_qry_s;
  logic          fin_edge_s;
  logic [1:0]    ref_sym_s;
  logic [1:0]    qry_sym_s;

  assign wr_addr_ext_s = {1'b0, wr_addr};
  assign wr_ref_s   = wr_en && (state_q == ST_IDLE) && !wr_sel && (wr_addr_ext_s < K_REF);
  assign wr_qry_s   = wr_en && (state_q == ST_IDLE) && wr_sel && (wr_addr_ext_s < K_QRY);
  assign fin_edge_s = finish && !finish_dly_q && (state_q == ST_WAIT);

  // Buffers are deliberately outside the reset domain so contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_ref_s) begin
      ref_mem[wr_addr_ext_s[AWR-1:0]] <= wr_data;
    end
    if (wr_qry_s) begin
      qry_mem[wr_addr_ext_s[AWQ-1:0]] <= wr_data;
    end
  end

  // Beat 0 is launched from IDLE, so a same-cycle write to that index is forwarded.
  always_comb begin
    if (state_q == ST_IDLE) begin
      idx_s = K_ZERO;
    end else begin
      idx_s = k_q;
    end
    ref_sym_s = 2'b00;
    qry_sym_s = 2'b00;
    if (idx_s < K_REF) begin
      if (wr_ref_s && (wr_addr_ext_s == idx_s)) begin
        ref_sym_s = wr_data;
      end else begin
        ref_sym_s = ref_mem[idx_s[AWR-1:0]];
      end
    end else begin
      ref_sym_s = 2'b00;
    end
    if (idx_s < K_QRY) begin
      if (wr_qry_s && (wr_addr_ext_s == idx_s)) begin
        qry_sym_s = wr_data;
      end else begin
        qry_sym_s = qry_mem[idx_s[AWQ-1:0]];
      end
    end else begin
      qry_sym_s = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (k_q == K_REF) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (fin_edge_s || (wd_q == WD_MAX)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // k_q holds the index of the next beat to load; reaching LEN_REF ends the stream.
  always_comb begin
    valid_d         = 1'b0;
    data_ref_d      = 2'b00;
    data_query_d    = 2'b00;
    busy_d          = 1'b0;
    done_d          = 1'b0;
    timeout_d       = timeout_q;
    res_max_d       = res_max_q;
    res_pos_ref_d   = res_pos_ref_q;
    res_pos_query_d = res_pos_query_q;
    k_d             = k_q;
    wd_d            = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          valid_d      = 1'b1;
          data_ref_d   = ref_sym_s;
          data_query_d = qry_sym_s;
          busy_d       = 1'b1;
          timeout_d    = 1'b0;
          k_d          = K_ONE;
        end else begin
          k_d = K_ZERO;
        end
      end
      ST_SEND: begin
        busy_d = 1'b1;
        if (k_q == K_REF) begin
          k_d  = K_ZERO;
          wd_d = 10'd0;
        end else begin
          valid_d      = 1'b1;
          data_ref_d   = ref_sym_s;
          data_query_d = qry_sym_s;
          k_d          = k_q + K_ONE;
        end
      end
      ST_WAIT: begin
        if (fin_edge_s) begin
          res_max_d       = max;
          res_pos_ref_d   = pos_ref;
          res_pos_query_d = pos_query;
          done_d          = 1'b1;
        end else if (wd_q == WD_MAX) begin
          res_max_d       = {WIDTH_SCORE{1'b0}};
          res_pos_ref_d   = {WIDTH_POS_REF{1'b0}};
          res_pos_query_d = {WIDTH_POS_QUERY{1'b0}};
          timeout_d       = 1'b1;
          done_d          = 1'b1;
        end else begin
          busy_d = 1'b1;
          wd_d   = wd_q + 10'd1;
        end
      end
      ST_DONE: wd_d = 10'd0;
      default: begin
        k_d  = K_ZERO;
        wd_d = 10'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q             <= K_ZERO;
      wd_q            <= 10'd0;
      finish_dly_q    <= 1'b0;
      valid_q         <= 1'b0;
      data_ref_q      <= 2'b00;
      data_query_q    <= 2'b00;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      timeout_q       <= 1'b0;
      res_max_q       <= {WIDTH_SCORE{1'b0}};
      res_pos_ref_q   <= {WIDTH_POS_REF{1'b0}};
      res_pos_query_q <= {WIDTH_POS_QUERY{1'b0}};
    end else begin
      k_q             <= k_d;
      wd_q            <= wd_d;
      finish_dly_q    <= finish;
      valid_q         <= valid_d;
      data_ref_q      <= data_ref_d;
      data_query_q    <= data_query_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      timeout_q       <= timeout_d;
      res_max_q       <= res_max_d;
      res_pos_ref_q   <= res_pos_ref_d;
      res_pos_query_q <= res_pos_query_d;
    end
  end

  assign valid         = valid_q;
  assign data_ref      = data_ref_q;
  assign data_query    = data_query_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign timeout       = timeout_q;
  assign res_max       = res_max_q;
  assign res_pos_ref   = res_pos_ref_q;
  assign res_pos_query = res_pos_query_q;

endmodule
